// File: rtl/mips_ctrl_if.sv
// Control/handshake bundle between the multi-cycle MIPS controller and its datapath.
// master = controller side, slave = datapath/memory side.
interface mips_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic             mem_ready;
    logic             pc_wr;
    logic             pc_wr_cond;
    logic             i_or_d;
    logic             mem_rd;
    logic             mem_wr;
    logic             ir_wr;
    logic             reg_wr;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic [1:0]       pc_src;
    logic             ext_op;
    logic [3:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  op, mem_ready,
        output pc_wr, pc_wr_cond, i_or_d, mem_rd, mem_wr, ir_wr, reg_wr, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, ext_op,
               state, illegal, retired
    );

    modport slave (
        output op, mem_ready,
        input  pc_wr, pc_wr_cond, i_or_d, mem_rd, mem_wr, ir_wr, reg_wr, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, ext_op,
               state, illegal, retired
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore sequencer for the multi-cycle MIPS datapath: fetch/decode/execute/memory/write-back,
// memory ready stalls, sticky trap on unknown opcodes, retired-instruction counter.
//
// state | meaning
// IF    | fetch instruction, PC += 4 when memory ready
// ID    | decode, precompute branch target
// MADR  | load/store address
// MRD   | data read
// WBM   | load write-back
// MWR   | data write
// EXR   | R-type execute
// WBR   | R-type write-back
// BEQ   | compare and conditional PC write
// JMP   | jump
// EXI   | addi/ori execute
// WBI   | immediate write-back
// TRAP  | unsupported opcode, held until reset
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    mips_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_IF   = 4'd0,  S_ID  = 4'd1,  S_MADR = 4'd2,  S_MRD = 4'd3,
        S_WBM  = 4'd4,  S_MWR = 4'd5,  S_EXR  = 4'd6,  S_WBR = 4'd7,
        S_BEQ  = 4'd8,  S_JMP = 4'd9,  S_EXI  = 4'd10, S_WBI = 4'd11,
        S_TRAP = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    state_t           state_q, state_d;
    logic             ori_q, ori_d;
    logic             sw_q, sw_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IF;
            ori_q     <= 1'b0;
            sw_q      <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ori_q     <= ori_d;
            sw_q      <= sw_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // op is only looked at in ID; later states use the latched ori/sw flags
    always_comb begin
        state_d   = S_IF;
        ori_d     = ori_q;
        sw_d      = sw_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        case (state_q)
            S_IF:   state_d = bus.mem_ready ? S_ID : S_IF;
            S_ID: begin
                ori_d = (bus.op == OP_ORI);
                sw_d  = (bus.op == OP_SW);
                case (bus.op)
                    OP_RTYPE:        state_d = S_EXR;
                    OP_LW, OP_SW:    state_d = S_MADR;
                    OP_BEQ:          state_d = S_BEQ;
                    OP_J:            state_d = S_JMP;
                    OP_ADDI, OP_ORI: state_d = S_EXI;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MADR: state_d = sw_q ? S_MWR : S_MRD;
            S_MRD:  state_d = bus.mem_ready ? S_WBM : S_MRD;
            S_MWR: begin
                if (bus.mem_ready) begin
                    state_d   = S_IF;
                    retired_d = retired_q + CNT_W'(1);
                end else begin
                    state_d = S_MWR;
                end
            end
            S_EXR:  state_d = S_WBR;
            S_EXI:  state_d = S_WBI;
            S_WBM, S_WBR, S_BEQ, S_JMP, S_WBI: begin
                state_d   = S_IF;
                retired_d = retired_q + CNT_W'(1);
            end
            S_TRAP: begin
                state_d   = S_TRAP;
                illegal_d = 1'b1;
            end
            default: state_d = S_IF;
        endcase
    end

    // Controls are gated by reset so nothing (not even the fetch read) is requested while held.
    always_comb begin
        bus.pc_wr      = 1'b0;
        bus.pc_wr_cond = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.ir_wr      = 1'b0;
        bus.reg_wr     = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 3'b000;
        bus.pc_src     = 2'b00;
        bus.ext_op     = 1'b0;
        if (reset) begin
            bus.ext_op = 1'b1;
            case (state_q)
                S_IF: begin
                    bus.mem_rd    = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.ir_wr     = bus.mem_ready;
                    bus.pc_wr     = bus.mem_ready;
                end
                S_ID:   bus.alu_src_b = 2'b11;
                S_MADR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                end
                S_MRD: begin
                    bus.mem_rd = 1'b1;
                    bus.i_or_d = 1'b1;
                end
                S_WBM: begin
                    bus.reg_wr     = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                S_MWR: begin
                    bus.mem_wr = 1'b1;
                    bus.i_or_d = 1'b1;
                end
                S_EXR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 3'b010;
                end
                S_WBR: begin
                    bus.reg_wr  = 1'b1;
                    bus.reg_dst = 1'b1;
                end
                S_BEQ: begin
                    bus.alu_src_a  = 1'b1;
                    bus.alu_op     = 3'b001;
                    bus.pc_wr_cond = 1'b1;
                    bus.pc_src     = 2'b01;
                end
                S_JMP: begin
                    bus.pc_wr  = 1'b1;
                    bus.pc_src = 2'b10;
                end
                S_EXI: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    bus.alu_op    = ori_q ? 3'b011 : 3'b000;
                    bus.ext_op    = ~ori_q;
                end
                S_WBI: begin
                    bus.reg_wr = 1'b1;
                    bus.ext_op = ~ori_q;
                end
                S_TRAP:  bus.ext_op = 1'b0;
                default: bus.ext_op = 1'b1;
            endcase
        end
    end

    assign bus.state   = state_q;
    assign bus.illegal = illegal_q;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-cycle state and packed control vector checks.
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    mips_ctrl_if #(.CNT_W(32)) bus ();

    mips_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // {pc_wr, pc_wr_cond, i_or_d, mem_rd, mem_wr, ir_wr, reg_wr, reg_dst, mem_to_reg,
    //  alu_src_a, alu_src_b[1:0], alu_op[2:0], pc_src[1:0], ext_op}
    logic [17:0] ctl;
    assign ctl = {bus.pc_wr, bus.pc_wr_cond, bus.i_or_d, bus.mem_rd, bus.mem_wr, bus.ir_wr,
                  bus.reg_wr, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
                  bus.alu_op, bus.pc_src, bus.ext_op};

    localparam logic [17:0] C_ZERO  = 18'b0;
    localparam logic [17:0] C_IF_R  = 18'b1_0_0_1_0_1_0_0_0_0_01_000_00_1;
    localparam logic [17:0] C_IF_S  = 18'b0_0_0_1_0_0_0_0_0_0_01_000_00_1;
    localparam logic [17:0] C_ID    = 18'b0_0_0_0_0_0_0_0_0_0_11_000_00_1;
    localparam logic [17:0] C_MADR  = 18'b0_0_0_0_0_0_0_0_0_1_10_000_00_1;
    localparam logic [17:0] C_MRD   = 18'b0_0_1_1_0_0_0_0_0_0_00_000_00_1;
    localparam logic [17:0] C_WBM   = 18'b0_0_0_0_0_0_1_0_1_0_00_000_00_1;
    localparam logic [17:0] C_MWR   = 18'b0_0_1_0_1_0_0_0_0_0_00_000_00_1;
    localparam logic [17:0] C_EXR   = 18'b0_0_0_0_0_0_0_0_0_1_00_010_00_1;
    localparam logic [17:0] C_WBR   = 18'b0_0_0_0_0_0_1_1_0_0_00_000_00_1;
    localparam logic [17:0] C_BEQ   = 18'b0_1_0_0_0_0_0_0_0_1_00_001_01_1;
    localparam logic [17:0] C_JMP   = 18'b1_0_0_0_0_0_0_0_0_0_00_000_10_1;
    localparam logic [17:0] C_EXI_A = 18'b0_0_0_0_0_0_0_0_0_1_10_000_00_1;
    localparam logic [17:0] C_EXI_O = 18'b0_0_0_0_0_0_0_0_0_1_10_011_00_0;
    localparam logic [17:0] C_WBI_A = 18'b0_0_0_0_0_0_1_0_0_0_00_000_00_1;
    localparam logic [17:0] C_WBI_O = 18'b0_0_0_0_0_0_1_0_0_0_00_000_00_0;

    task automatic test_reset();
        reset = 1'b0;
        bus.op = 6'b000000;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
        total++; if (ctl !== C_ZERO) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_ZERO); end
        total++; if (bus.retired !== 32'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", bus.retired); end
        total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", bus.illegal); end
        reset = 1'b1;
        #1;
        total++; if (ctl !== C_IF_R) begin bad++; $display("FAIL first_fetch_ctl got=%b exp=%b", ctl, C_IF_R); end
    endtask

    task automatic test_rtype();
        logic [3:0]  st [4];
        logic        rd [4];
        logic [17:0] ex [4];
        st = '{4'd0, 4'd1, 4'd6, 4'd7};
        rd = '{1'b1, 1'b0, 1'b0, 1'b0};
        ex = '{C_IF_R, C_ID, C_EXR, C_WBR};
        bus.op = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = rd[i];
            #1;
            total++; if (bus.state !== st[i]) begin bad++; $display("FAIL rtype_state step=%0d got=%0d exp=%0d", i, bus.state, st[i]); end
            total++; if (ctl !== ex[i]) begin bad++; $display("FAIL rtype_ctl step=%0d got=%b exp=%b", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        total++; if (bus.state !== 4'd0) begin bad++; $display("FAIL rtype_end_state got=%0d exp=0", bus.state); end
        total++; if (bus.retired !== 32'd1) begin bad++; $display("FAIL rtype_retired got=%0d exp=1", bus.retired); end
    endtask

    task automatic test_lw_stall();
        logic [3:0]  st [7];
        logic        rd [7];
        logic [17:0] ex [7];
        st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
        rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ex = '{C_IF_R, C_ID, C_MADR, C_MRD, C_MRD, C_MRD, C_WBM};
        bus.op = 6'b100011;
        for (int i = 0; i < 7; i++) begin
            bus.mem_ready = rd[i];
            #1;
            total++; if (bus.state !== st[i]) begin bad++; $display("FAIL lw_state step=%0d got=%0d exp=%0d", i, bus.state, st[i]); end
            total++; if (ctl !== ex[i]) begin bad++; $display("FAIL lw_ctl step=%0d got=%b exp=%b", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        total++; if (bus.state !== 4'd0) begin bad++; $display("FAIL lw_end_state got=%0d exp=0", bus.state); end
        total++; if (bus.retired !== 32'd2) begin bad++; $display("FAIL lw_retired got=%0d exp=2", bus.retired); end
    endtask

    task automatic test_sw_fetch_stall();
        logic [3:0]  st [5];
        logic        rd [5];
        logic [17:0] ex [5];
        st = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd5};
        rd = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        ex = '{C_IF_S, C_IF_R, C_ID, C_MADR, C_MWR};
        bus.op = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            bus.mem_ready = rd[i];
            #1;
            total++; if (bus.state !== st[i]) begin bad++; $display("FAIL sw_state step=%0d got=%0d exp=%0d", i, bus.state, st[i]); end
            total++; if (ctl !== ex[i]) begin bad++; $display("FAIL sw_ctl step=%0d got=%b exp=%b", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        total++; if (bus.state !== 4'd0) begin bad++; $display("FAIL sw_end_state got=%0d exp=0", bus.state); end
        total++; if (bus.retired !== 32'd3) begin bad++; $display("FAIL sw_retired got=%0d exp=3", bus.retired); end
    endtask

    task automatic test_back_to_back_beq_j();
        logic [3:0]  st [6];
        logic [5:0]  opv [6];
        logic [17:0] ex [6];
        st  = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9};
        opv = '{6'b000100, 6'b000100, 6'b000100, 6'b000010, 6'b000010, 6'b000010};
        ex  = '{C_IF_R, C_ID, C_BEQ, C_IF_R, C_ID, C_JMP};
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.op = opv[i];
            #1;
            total++; if (bus.state !== st[i]) begin bad++; $display("FAIL beqj_state step=%0d got=%0d exp=%0d", i, bus.state, st[i]); end
            total++; if (ctl !== ex[i]) begin bad++; $display("FAIL beqj_ctl step=%0d got=%b exp=%b", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        total++; if (bus.retired !== 32'd5) begin bad++; $display("FAIL beqj_retired got=%0d exp=5", bus.retired); end
    endtask

    task automatic test_imm();
        logic [3:0]  st [8];
        logic [5:0]  opv [8];
        logic [17:0] ex [8];
        st  = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0, 4'd1, 4'd10, 4'd11};
        opv = '{6'b001101, 6'b001101, 6'b001101, 6'b001101,
                6'b001000, 6'b001000, 6'b001000, 6'b001000};
        ex  = '{C_IF_R, C_ID, C_EXI_O, C_WBI_O, C_IF_R, C_ID, C_EXI_A, C_WBI_A};
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.op = opv[i];
            #1;
            total++; if (bus.state !== st[i]) begin bad++; $display("FAIL imm_state step=%0d got=%0d exp=%0d", i, bus.state, st[i]); end
            total++; if (ctl !== ex[i]) begin bad++; $display("FAIL imm_ctl step=%0d got=%b exp=%b", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        total++; if (bus.retired !== 32'd7) begin bad++; $display("FAIL imm_retired got=%0d exp=7", bus.retired); end
        total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL imm_illegal got=%b exp=0", bus.illegal); end
    endtask

    task automatic test_trap();
        bus.op = 6'b111111;
        bus.mem_ready = 1'b1;
        #1;
        total++; if (bus.state !== 4'd0) begin bad++; $display("FAIL trap_if_state got=%0d exp=0", bus.state); end
        @(posedge clk); #1;
        total++; if (ctl !== C_ID) begin bad++; $display("FAIL trap_id_ctl got=%b exp=%b", ctl, C_ID); end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = i[0];
            #1;
            total++; if (bus.state !== 4'd12) begin bad++; $display("FAIL trap_state cyc=%0d got=%0d exp=12", i, bus.state); end
            total++; if (ctl !== C_ZERO) begin bad++; $display("FAIL trap_ctl cyc=%0d got=%b exp=%b", i, ctl, C_ZERO); end
            total++; if (bus.illegal !== 1'b1) begin bad++; $display("FAIL trap_illegal cyc=%0d got=%b exp=1", i, bus.illegal); end
            total++; if (bus.retired !== 32'd7) begin bad++; $display("FAIL trap_retired cyc=%0d got=%0d exp=7", i, bus.retired); end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        total++; if (bus.state !== 4'd0) begin bad++; $display("FAIL trap_rst_state got=%0d exp=0", bus.state); end
        total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL trap_rst_illegal got=%b exp=0", bus.illegal); end
        total++; if (bus.retired !== 32'd0) begin bad++; $display("FAIL trap_rst_retired got=%0d exp=0", bus.retired); end
        total++; if (ctl !== C_ZERO) begin bad++; $display("FAIL trap_rst_ctl got=%b exp=%b", ctl, C_ZERO); end
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset_mid_stall();
        bus.op = 6'b100011;
        bus.mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        bus.mem_ready = 1'b0;
        #1;
        total++; if (bus.state !== 4'd3) begin bad++; $display("FAIL stall_state got=%0d exp=3", bus.state); end
        total++; if (ctl !== C_MRD) begin bad++; $display("FAIL stall_ctl got=%b exp=%b", ctl, C_MRD); end
        reset = 1'b0;
        #1;
        total++; if (bus.state !== 4'd0) begin bad++; $display("FAIL stall_rst_state got=%0d exp=0", bus.state); end
        total++; if (ctl !== C_ZERO) begin bad++; $display("FAIL stall_rst_ctl got=%b exp=%b", ctl, C_ZERO); end
        @(posedge clk); #1;
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        total++; if (ctl !== C_IF_S) begin bad++; $display("FAIL stall_refetch_ctl got=%b exp=%b", ctl, C_IF_S); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw_fetch_stall();
        test_back_to_back_beq_j();
        test_imm();
        test_trap();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
